// File: rtl/equilibrium_maxxing_pkg.sv
// Shared types and constants for the equilibrium_maxxing referee datapath.
package equilibrium_maxxing_pkg;
   localparam int         ANG_W     = 8;
   localparam int         SCORE_W   = 8;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;  // taps 8,6,5,4

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_WAIT = 3'd2,
      S_PLAY = 3'd3
   } state_t;
endpackage

// File: rtl/equilibrium_maxxing_lfsr.sv
// 8-bit Fibonacci LFSR target generator; one step per adv_i, never reaches 0.
module equilibrium_maxxing_lfsr
   import equilibrium_maxxing_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       adv_i,
   output logic [7:0] val_o
);
   logic [7:0] lfsr_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lfsr_q <= SEED;
      end else if (adv_i) begin
         lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
      end
   end

   assign val_o = lfsr_q;
endmodule

// File: rtl/equilibrium_maxxing_juiz.sv
// Referee: prep timer, target latch, hold/timeout judging and saturating score.
// Optional macro EQUILIBRIUM_MAXXING_DIFICULDADE_EN shrinks tolerance as the score grows.
module equilibrium_maxxing_juiz
   import equilibrium_maxxing_pkg::*;
#(
   parameter int         PREP_CYCLES    = 50000000,
   parameter int         HOLD_CYCLES    = 25000000,
   parameter int         TIMEOUT_CYCLES = 500000000,
   parameter int         TOL            = 8,
   parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               external,
   input  logic               reset_nivel,
   input  logic               reset_prep_cnt,
   input  logic               gerar_nova_jogada,
   input  logic               conta_nivel,
   input  logic [ANG_W-1:0]   angulo,
   output logic               prep_done,
   output logic               ponto_evento,
   output logic               acerto,
   output logic [ANG_W-1:0]   alvo,
   output logic [SCORE_W-1:0] pontuacao,
   output logic [2:0]         db_estado
);
   localparam logic [31:0] PREP_LAST = PREP_CYCLES - 1;
   localparam logic [31:0] HOLD_LAST = HOLD_CYCLES - 1;
   localparam logic [31:0] TMO_LAST  = TIMEOUT_CYCLES - 1;

   state_t             state_q;
   logic [31:0]        prep_cnt_q, hold_cnt_q, tmo_cnt_q;
   logic               prep_done_q, ponto_q, acerto_q;
   logic [ANG_W-1:0]   alvo_q;
   logic [SCORE_W-1:0] score_q;
   logic [ANG_W-1:0]   lfsr_val;
   logic               lfsr_adv;
   logic [ANG_W:0]     ang_ext, alvo_ext, diff, tol_eff;
   logic               in_tol, hit, timeout;

   assign lfsr_adv = external && (state_q == S_PREP) && gerar_nova_jogada;

   equilibrium_maxxing_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clock (clock),
      .reset (reset),
      .adv_i (lfsr_adv),
      .val_o (lfsr_val)
   );

`ifdef EQUILIBRIUM_MAXXING_DIFICULDADE_EN
   int tol_shrunk;
   always_comb begin
      tol_shrunk = TOL - int'(score_q >> 2);
      tol_eff    = (tol_shrunk < 1) ? 9'd1 : 9'(tol_shrunk);
   end
`else
   assign tol_eff = 9'(TOL);
`endif

   // 9-bit magnitude so the difference never wraps
   always_comb begin
      ang_ext  = {1'b0, angulo};
      alvo_ext = {1'b0, alvo_q};
      diff     = (ang_ext >= alvo_ext) ? (ang_ext - alvo_ext) : (alvo_ext - ang_ext);
      in_tol   = (diff <= tol_eff);
      hit      = in_tol && (hold_cnt_q == HOLD_LAST);
      timeout  = (tmo_cnt_q == TMO_LAST);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         prep_cnt_q  <= '0;
         hold_cnt_q  <= '0;
         tmo_cnt_q   <= '0;
         prep_done_q <= 1'b0;
         ponto_q     <= 1'b0;
         acerto_q    <= 1'b0;
         alvo_q      <= '0;
         score_q     <= '0;
      end else begin
         ponto_q <= 1'b0;
         if (!external) begin
            state_q     <= S_IDLE;
            prep_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            prep_done_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q    <= S_PREP;
                  prep_cnt_q <= '0;
               end
               S_PREP: begin
                  if (gerar_nova_jogada) begin
                     state_q     <= S_WAIT;
                     alvo_q      <= lfsr_val;
                     prep_done_q <= 1'b0;
                     hold_cnt_q  <= '0;
                     tmo_cnt_q   <= '0;
                  end else if (reset_prep_cnt) begin
                     prep_cnt_q <= '0;
                  end else if (prep_cnt_q == PREP_LAST) begin
                     prep_done_q <= 1'b1;
                  end else begin
                     prep_cnt_q <= prep_cnt_q + 32'd1;
                  end
               end
               S_WAIT: begin
                  hold_cnt_q <= '0;
                  tmo_cnt_q  <= '0;
                  if (conta_nivel) state_q <= S_PLAY;
               end
               S_PLAY: begin
                  if (conta_nivel) begin
                     if (hit || timeout) begin
                        // a hit on the final timeout cycle still counts
                        ponto_q    <= 1'b1;
                        acerto_q   <= hit;
                        if (hit && score_q != 8'hFF) score_q <= score_q + 8'd1;
                        state_q    <= S_PREP;
                        prep_cnt_q <= '0;
                        hold_cnt_q <= '0;
                        tmo_cnt_q  <= '0;
                     end else begin
                        hold_cnt_q <= in_tol ? hold_cnt_q + 32'd1 : '0;
                        tmo_cnt_q  <= tmo_cnt_q + 32'd1;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
         if (reset_nivel) score_q <= '0;
      end
   end

   assign prep_done    = prep_done_q;
   assign ponto_evento = ponto_q;
   assign acerto       = acerto_q;
   assign alvo         = alvo_q;
   assign pontuacao    = score_q;
   assign db_estado    = state_q;
endmodule

// File: doc/equilibrium_maxxing_juiz.md
Name: equilibrium_maxxing_juiz

Overview:
Referee datapath that answers the game control unit's strobes. It produces prep_done, which ends the Prep phase, and ponto_evento, which ends the Joga phase. It latches a pseudo-random target angle on each gerar_nova_jogada request and judges the platform angle against that target. It keeps the player score.

Parameters:
PREP_CYCLES, 50000000, clock cycles the Prep phase lasts before prep_done is raised
HOLD_CYCLES, 25000000, consecutive in-tolerance cycles required for a hit
TIMEOUT_CYCLES, 500000000, play-window length before a miss is declared
TOL, 8, allowed |angulo - alvo|, unsigned
LFSR_SEED, 8'hA5, non-zero reset value of the 8-bit target LFSR

Ports:
clock  in  1  system clock
reset  in  1  reset; asynchronous and active-high
external  in  1  high while the UC is in Prep, genNext or Joga; low aborts to idle
reset_nivel  in  1  clears the score, synchronous to clock
reset_prep_cnt  in  1  synchronous clear of the prep counter
gerar_nova_jogada  in  1  1-cycle request to latch a new target
conta_nivel  in  1  high while the UC is in Joga; enables the play timers
angulo  in  8  current platform angle, unsigned, sampled every cycle
prep_done  out  1  level; high from Prep-count completion until gerar_nova_jogada
ponto_evento  out  1  1-cycle pulse when a round is judged
acerto  out  1  result of the last round: 1 = hit, 0 = miss; held
alvo  out  8  current target angle
pontuacao  out  8  hit count, saturating
db_estado  out  3  current FSM state

Behaviour:
- Reset values: all outputs 0 except alvo = 0. LFSR = LFSR_SEED; FSM = S_IDLE; all counters 0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances once per gerar_nova_jogada. Never reaches 0.
- FSM states: S_IDLE=0, S_PREP=1, S_WAIT=2, S_PLAY=3.
- Abort rule: in every state, external=0 forces S_IDLE on the next cycle. It clears prep_done and the play counters and emits no ponto_evento.
- S_IDLE:
  - external=1 -> S_PREP with prep_cnt=0.
- S_PREP:
  - prep_cnt increments each cycle unless reset_prep_cnt=1, which forces it to 0.
  - When prep_cnt == PREP_CYCLES-1, prep_done is registered high next cycle and prep_cnt stops.
  - prep_done stays high until gerar_nova_jogada.
  - gerar_nova_jogada (with or without prep_done) -> S_WAIT. On that edge: alvo <= LFSR, LFSR advances, prep_done <= 0.
- S_WAIT:
  - Play counters are held at 0.
  - conta_nivel=1 -> S_PLAY. Counting starts in the first S_PLAY cycle.
- S_PLAY, each cycle with conta_nivel=1:
  - Difference: diff = |angulo - alvo|, computed in 9 bits, no wrap.
  - Hold counter: if diff <= TOL_eff, hold_cnt increments; else hold_cnt resets to 0.
  - Timer: tmo_cnt increments every cycle.
  - With conta_nivel=0, both counters hold.
- Judging, in S_PLAY:
  - Hit: hold_cnt reaches HOLD_CYCLES-1 while in tolerance. Then acerto <= 1, pontuacao saturates at 255 on +1, and ponto_evento is pulsed.
  - Miss: tmo_cnt reaches TIMEOUT_CYCLES-1 first. Then acerto <= 0 and ponto_evento is pulsed.
  - Hit and timeout in the same cycle: hit wins.
  - After ponto_evento -> S_PREP with prep_cnt=0.
  - ponto_evento is registered: it is high the cycle after the decision and for exactly 1 cycle.
- reset_nivel=1: pontuacao <= 0 in any state. It does not change the FSM state.
- gerar_nova_jogada outside S_PREP: ignored; alvo and the LFSR are unchanged.
- Latency: angulo in tolerance for exactly HOLD_CYCLES cycles -> ponto_evento high 1 cycle later.

Optional Feature:
Macro: EQUILIBRIUM_MAXXING_DIFICULDADE_EN.
- Defined: TOL_eff = max(1, TOL - (pontuacao >> 2)), i.e. tolerance shrinks by 1 every 4 hits, floor 1.
- Undefined: TOL_eff = TOL, constant; no subtractor is synthesized.

Decomposition:
- Shared package equilibrium_maxxing_pkg holds:
  - FSM state encodings S_IDLE..S_PLAY (3 bits);
  - angle width ANG_W=8;
  - score width SCORE_W=8;
  - LFSR tap mask.
- One sub-module, equilibrium_maxxing_lfsr: 8-bit, with seed parameter, advance enable and value output.
- Counters and judging stay inline.

Test Plan:
Bench parameters: PREP_CYCLES=4, HOLD_CYCLES=3, TIMEOUT_CYCLES=10, TOL=2, LFSR_SEED=8'hA5.
1. Reset, then external=1 -> prep_done rises on cycle 5 after entering S_PREP. Then gerar_nova_jogada -> alvo=8'hA5, prep_done=0 next cycle.
2. S_PLAY with conta_nivel=1, angulo=alvo+2 for 3 cycles -> ponto_evento pulse 1 cycle, acerto=1, pontuacao=1, state S_PREP.
3. angulo=alvo+3 throughout -> ponto_evento at timeout (tmo_cnt=9), acerto=0, pontuacao unchanged.
4. In tolerance 2 cycles, out 1, then in 3 -> hold restarts; hit after 6 cycles total, no early pulse.
5. external dropped mid-S_PLAY -> S_IDLE, no ponto_evento; async reset mid-S_PREP -> all outputs 0 immediately.
6. With the macro defined: after 8 hits (pontuacao=8), TOL_eff=1 and angulo=alvo+2 -> timeout miss. Preload pontuacao=255 and hit -> stays 255.
